// File: rtl/md5_pkg.sv
// ============================================================================
// Module      : md5_pkg
// Description : Shared MD5 constants, controller state encoding and the
//               last-word padding helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md5_pkg;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hEFCDAB89;
    localparam logic [31:0] MD5_IV_C = 32'h98BADCFE;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

    localparam logic [3:0] LEN_LO_IDX = 4'd14;
    localparam logic [3:0] LEN_HI_IDX = 4'd15;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CRST    = 4'd1,
        DATA    = 4'd2,
        PAD     = 4'd3,
        LEN_LO  = 4'd4,
        LEN_HI  = 4'd5,
        BLKWAIT = 4'd6,
        FINWAIT = 4'd7,
        OUT     = 4'd8
    } ctrl_state_t;

    localparam logic [31:0] MD5_K [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts indexed by {round group, step mod 4}
    localparam logic [4:0] MD5_S [0:15] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    // Keeps bytes below nbytes, puts 0x80 at byte nbytes, zeros above it
    function automatic logic [31:0] pad_merge(input logic [31:0] word,
                                              input logic [2:0]  nbytes);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes)
                r[8*i +: 8] = word[8*i +: 8];
            else if (3'(i) == nbytes)
                r[8*i +: 8] = 8'h80;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md5_msg_ctrl_if.sv
// ============================================================================
// Module      : md5_msg_ctrl_if
// Description : Message word stream and digest handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md5_msg_ctrl_if;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [2:0]   s_bytes;
    logic         s_ready;
    logic [127:0] dig_data;
    logic         dig_valid;
    logic         dig_ready;

    modport master (
        output s_data, s_valid, s_last, s_bytes, dig_ready,
        input  s_ready, dig_data, dig_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, s_bytes, dig_ready,
        output s_ready, dig_data, dig_valid
    );
endinterface

`default_nettype wire

// File: rtl/md5sum.sv
// ============================================================================
// Module      : md5sum
// Description : MD5 block core: takes 16 words, runs 64 rounds (one per
//               cycle) and accumulates into the a/b/c/d chaining registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md5sum
    import md5_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        we,
    input  wire logic [31:0] din,
    output logic             rdy,
    output logic             done,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [31:0]      c,
    output logic [31:0]      d
);

    typedef enum logic [0:0] {
        RECVWAIT = 1'b0,
        COMPUTE  = 1'b1
    } core_state_t;

    core_state_t r_state, w_state_nxt;
    logic [3:0]  r_widx;
    logic [5:0]  r_rnd;
    logic [31:0] r_m [0:15];
    logic [31:0] r_a, r_b, r_c, r_d;
    logic [31:0] r_h0, r_h1, r_h2, r_h3;
    logic        r_done;
    logic [31:0] w_f, w_sum, w_rot, w_b_new;
    logic [3:0]  w_g;
    logic [4:0]  w_s;

    always_comb begin
        w_f = '0;
        w_g = '0;
        case (r_rnd[5:4])
            2'd0: begin w_f = (r_b & r_c) | (~r_b & r_d); w_g = r_rnd[3:0];                 end
            2'd1: begin w_f = (r_d & r_b) | (~r_d & r_c); w_g = r_rnd[3:0] * 4'd5 + 4'd1;   end
            2'd2: begin w_f = r_b ^ r_c ^ r_d;            w_g = r_rnd[3:0] * 4'd3 + 4'd5;   end
            default: begin w_f = r_c ^ (r_b | ~r_d);      w_g = r_rnd[3:0] * 4'd7;          end
        endcase
        w_s     = MD5_S[{r_rnd[5:4], r_rnd[1:0]}];
        w_sum   = r_a + w_f + MD5_K[r_rnd] + r_m[w_g];
        w_rot   = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));
        w_b_new = r_b + w_rot;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RECVWAIT: if (we && r_widx == 4'd15) w_state_nxt = COMPUTE;
            COMPUTE:  if (r_rnd == 6'd63)        w_state_nxt = RECVWAIT;
            default:                             w_state_nxt = RECVWAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == RECVWAIT && we)
            r_m[r_widx] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RECVWAIT;
            r_widx  <= '0;
            r_rnd   <= '0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_h0    <= MD5_IV_A;
            r_h1    <= MD5_IV_B;
            r_h2    <= MD5_IV_C;
            r_h3    <= MD5_IV_D;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (r_state == RECVWAIT && we) begin
                r_widx <= r_widx + 4'd1;
                if (r_widx == 4'd15) begin
                    r_a   <= r_h0;
                    r_b   <= r_h1;
                    r_c   <= r_h2;
                    r_d   <= r_h3;
                    r_rnd <= '0;
                end
            end
            if (r_state == COMPUTE) begin
                r_a   <= r_d;
                r_b   <= w_b_new;
                r_c   <= r_b;
                r_d   <= r_c;
                r_rnd <= r_rnd + 6'd1;
                // Final round: fold the round outputs into the chaining state
                if (r_rnd == 6'd63) begin
                    r_h0   <= r_h0 + r_d;
                    r_h1   <= r_h1 + w_b_new;
                    r_h2   <= r_h2 + r_b;
                    r_h3   <= r_h3 + r_c;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign rdy  = (r_state == RECVWAIT);
    assign done = r_done;
    assign a    = r_h0;
    assign b    = r_h1;
    assign c    = r_h2;
    assign d    = r_h3;

endmodule

`default_nettype wire

// File: rtl/md5_msg_ctrl.sv
// ============================================================================
// Module      : md5_msg_ctrl
// Description : Streams a byte message into md5sum with MD5 padding and
//               length, presents the 128-bit digest on valid/ready.
//               Optional MD5_MSG_CTRL_STATS_EN adds message/block counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md5_msg_ctrl
    import md5_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    md5_msg_ctrl_if.slave  bus
`ifdef MD5_MSG_CTRL_STATS_EN
    ,
    output logic [15:0]    stat_msgs,
    output logic [31:0]    stat_blks
`endif
);

    ctrl_state_t      r_state, w_state_nxt, w_tail;
    logic [3:0]       r_wcnt;
    logic [LEN_W-1:0] r_bcnt;
    logic             r_need80;
    logic             r_msg_end;
    logic [127:0]     r_dig_data;
    logic             r_dig_valid;
    logic             w_core_rst_n, w_core_we, w_core_rdy, w_core_done, w_xfer;
    logic [31:0]      w_core_din, w_core_a, w_core_b, w_core_c, w_core_d;
    logic [2:0]       w_nbytes;
    logic [63:0]      w_len;
    logic             w_s_ready;

    assign w_nbytes     = bus.s_last ? bus.s_bytes : 3'd4;
    assign w_len        = 64'({r_bcnt, 3'b000});
    assign w_core_rst_n = ~rst & (r_state != CRST);
    assign w_xfer       = w_core_we & w_core_rdy;

    // Next state after a word once the message body has ended
    assign w_tail = (r_wcnt == LEN_LO_IDX - 4'd1) ? LEN_LO :
                    (r_wcnt == LEN_HI_IDX)        ? BLKWAIT : PAD;

    always_comb begin
        w_state_nxt = r_state;
        w_core_we   = 1'b0;
        w_core_din  = '0;
        w_s_ready   = 1'b0;
        case (r_state)
            IDLE: if (bus.s_valid) w_state_nxt = CRST;
            CRST: w_state_nxt = DATA;
            DATA: begin
                w_core_we  = bus.s_valid;
                w_core_din = pad_merge(bus.s_data, w_nbytes);
                w_s_ready  = w_core_rdy;
                if (bus.s_valid && w_core_rdy) begin
                    if (bus.s_last) begin
                        // A full last word still owes a separate 0x80 word
                        if (bus.s_bytes == 3'd4)
                            w_state_nxt = (r_wcnt == LEN_HI_IDX) ? BLKWAIT : PAD;
                        else
                            w_state_nxt = w_tail;
                    end else if (r_wcnt == LEN_HI_IDX) begin
                        w_state_nxt = BLKWAIT;
                    end
                end
            end
            PAD: begin
                w_core_we  = 1'b1;
                w_core_din = r_need80 ? 32'h0000_0080 : 32'h0;
                if (w_core_rdy) w_state_nxt = w_tail;
            end
            LEN_LO: begin
                w_core_we  = 1'b1;
                w_core_din = w_len[31:0];
                if (w_core_rdy) w_state_nxt = LEN_HI;
            end
            LEN_HI: begin
                w_core_we  = 1'b1;
                w_core_din = w_len[63:32];
                if (w_core_rdy) w_state_nxt = FINWAIT;
            end
            BLKWAIT: if (w_core_done) w_state_nxt = r_msg_end ? PAD : DATA;
            FINWAIT: if (w_core_done) w_state_nxt = OUT;
            OUT:     if (bus.dig_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wcnt      <= '0;
            r_bcnt      <= '0;
            r_need80    <= 1'b0;
            r_msg_end   <= 1'b0;
            r_dig_data  <= '0;
            r_dig_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CRST) begin
                r_wcnt    <= '0;
                r_bcnt    <= '0;
                r_need80  <= 1'b0;
                r_msg_end <= 1'b0;
            end
            if (w_xfer)
                r_wcnt <= r_wcnt + 4'd1;
            if (w_xfer && r_state == DATA) begin
                r_bcnt <= r_bcnt + LEN_W'(w_nbytes);
                if (bus.s_last) begin
                    r_msg_end <= 1'b1;
                    r_need80  <= (bus.s_bytes == 3'd4);
                end
            end
            if (w_xfer && r_state == PAD)
                r_need80 <= 1'b0;
            if (r_state == FINWAIT && w_core_done) begin
                r_dig_data  <= {w_core_d, w_core_c, w_core_b, w_core_a};
                r_dig_valid <= 1'b1;
            end
            if (r_state == OUT && bus.dig_ready)
                r_dig_valid <= 1'b0;
        end
    end

    md5sum u_core (
        .clk   (clk),
        .rst_n (w_core_rst_n),
        .we    (w_core_we),
        .din   (w_core_din),
        .rdy   (w_core_rdy),
        .done  (w_core_done),
        .a     (w_core_a),
        .b     (w_core_b),
        .c     (w_core_c),
        .d     (w_core_d)
    );

    assign bus.s_ready   = w_s_ready;
    assign bus.dig_data  = r_dig_data;
    assign bus.dig_valid = r_dig_valid;

`ifdef MD5_MSG_CTRL_STATS_EN
    logic [15:0] r_stat_msgs;
    logic [31:0] r_stat_blks;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_msgs <= '0;
            r_stat_blks <= '0;
        end else begin
            if (r_dig_valid && bus.dig_ready) r_stat_msgs <= r_stat_msgs + 16'd1;
            if (w_core_done)                  r_stat_blks <= r_stat_blks + 32'd1;
        end
    end

    assign stat_msgs = r_stat_msgs;
    assign stat_blks = r_stat_blks;
`endif

endmodule

`default_nettype wire

// File: tb/tb_md5_msg_ctrl.sv
// ============================================================================
// Module      : tb_md5_msg_ctrl
// Description : Directed self-checking bench for md5_msg_ctrl using RFC 1321
//               reference digests and padding/length word observations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md5_msg_ctrl;

    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md5_msg_ctrl_if bus ();

`ifdef MD5_MSG_CTRL_STATS_EN
    logic [15:0] stat_msgs;
    logic [31:0] stat_blks;
`endif

    md5_msg_ctrl #(.LEN_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef MD5_MSG_CTRL_STATS_EN
        ,
        .stat_msgs (stat_msgs),
        .stat_blks (stat_blks)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0]  words [$];
    logic [127:0] got;

    // Record every word handed to the core
    always @(negedge clk)
        if (dut.w_xfer) words.push_back(dut.w_core_din);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hex-string order (first byte leftmost) to dig_data layout (first byte in [7:0])
    function automatic logic [127:0] hex2dig(input logic [127:0] h);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127-8*i -: 8];
        return r;
    endfunction

    task automatic send_msg(input string m, input bit stall, input int max_words);
        int len, nw, nb, t;
        bit hs;
        logic [31:0] dw;
        len = m.len();
        nw  = (len == 0) ? 1 : (len + 3) / 4;
        words.delete();
        for (int w = 0; w < nw && w < max_words; w++) begin
            dw = '0;
            for (int k = 0; k < 4; k++)
                if (4*w + k < len) dw[8*k +: 8] = m[4*w + k];
            if (stall && w > 0 && $urandom_range(0, 2) == 0) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            nb = len - 4*w;
            if (nb > 4) nb = 4;
            bus.s_data  = dw;
            bus.s_last  = (w == nw - 1);
            bus.s_bytes = (w == nw - 1) ? 3'(nb) : 3'd0;
            bus.s_valid = 1'b1;
            t  = 0;
            hs = 1'b0;
            while (!hs && t < BUDGET) begin
                @(negedge clk);
                hs = bus.s_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!hs) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_ready_timeout observed=0 expected=1");
                $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
                $fatal(1, "handshake timeout");
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic get_digest(input string tag, input bit chk, input logic [127:0] exp_hex,
                              input int hold, output logic [127:0] obs);
        int t;
        t = 0;
        while (bus.dig_valid !== 1'b1 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, 128'(bus.dig_valid), 128'd1);
        obs = bus.dig_data;
        if (chk) check({tag, "_digest"}, bus.dig_data, hex2dig(exp_hex));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "_hold_valid"}, 128'(bus.dig_valid), 128'd1);
            check({tag, "_hold_data"}, bus.dig_data, obs);
            check({tag, "_hold_sready"}, 128'(bus.s_ready), 128'd0);
        end
        bus.dig_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.dig_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 128'(bus.dig_valid), 128'd0);
    endtask

    string s_alnum, s_digits, s_a56, s_a64;

    initial begin
        bus.s_data    = '0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.s_bytes   = '0;
        bus.dig_ready = 1'b0;
        s_alnum  = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
        s_digits = "12345678901234567890123456789012345678901234567890123456789012345678901234567890";
        s_a56    = "";
        for (int i = 0; i < 56; i++) s_a56 = {s_a56, "a"};
        s_a64    = {s_a56, "aaaaaaaa"};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready",   128'(bus.s_ready),   128'd0);
        check("rst_dig_valid", 128'(bus.dig_valid), 128'd0);
        check("rst_dig_data",  bus.dig_data,        128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Empty message: single 0x80 word, zero length
        send_msg("", 1'b0, 99);
        get_digest("empty", 1'b1, 128'hd41d8cd98f00b204e9800998ecf8427e, 0, got);
        check("empty_a",      128'(got[31:0]),  128'h d98c1dd4);
        check("empty_blocks", 128'(words.size()), 128'd16);
        check("empty_w0",     128'(words[0]),  128'h80);
        check("empty_w14",    128'(words[14]), 128'h0);

        // "abc" with consumer stalled 20 cycles
        send_msg("abc", 1'b0, 99);
        get_digest("abc", 1'b1, 128'h900150983cd24fb0d6963f7d28e17f72, 20, got);
        check("abc_a",   128'(got[31:0]),  128'h98500190);
        check("abc_w0",  128'(words[0]),  128'h80636261);
        check("abc_w14", 128'(words[14]), 128'h18);

        // Back-to-back repeat proves chaining state is cleared
        send_msg("abc", 1'b0, 99);
        get_digest("abc2", 1'b1, 128'h900150983cd24fb0d6963f7d28e17f72, 0, got);

        send_msg("a", 1'b0, 99);
        get_digest("one_a", 1'b1, 128'h0cc175b9c0f1b6a831c399e269772661, 0, got);

        send_msg("message digest", 1'b0, 99);
        get_digest("msgdig", 1'b1, 128'hf96b697d7cb7938d525a2f31aaf161d0, 0, got);

        // 56 bytes: 0x80 lands at word 14, length spills to an extra block
        send_msg(s_a56, 1'b0, 99);
        get_digest("a56", 1'b0, 128'h0, 0, got);
        check("a56_words",  128'(words.size()), 128'd32);
        check("a56_b1w14",  128'(words[14]), 128'h80);
        check("a56_b1w15",  128'(words[15]), 128'h0);
        check("a56_b2w0",   128'(words[16]), 128'h0);
        check("a56_b2w14",  128'(words[30]), 128'h1C0);
        check("a56_b2w15",  128'(words[31]), 128'h0);

        // 62 bytes: merged 0x80 lands at word 15
        send_msg(s_alnum, 1'b0, 99);
        get_digest("alnum", 1'b1, 128'hd174ab98d277d9f5a5611c2c9f419d9f, 0, got);
        check("alnum_words", 128'(words.size()), 128'd32);
        check("alnum_w15",   128'(words[15]), 128'h0080_3938);
        check("alnum_b2w14", 128'(words[30]), 128'h1F0);

        // 64 bytes with random source stalls
        send_msg(s_a64, 1'b1, 99);
        get_digest("a64", 1'b0, 128'h0, 0, got);
        check("a64_words", 128'(words.size()), 128'd32);
        check("a64_b2w0",  128'(words[16]), 128'h80);
        check("a64_b2w14", 128'(words[30]), 128'h200);
        check("a64_b2w15", 128'(words[31]), 128'h0);

        // 80 bytes with stalls; full last word mid-block
        send_msg(s_digits, 1'b1, 99);
        get_digest("digits", 1'b1, 128'h57edf4a22be3c955ac49da2e2107b67a, 0, got);
        check("digits_b2w4",  128'(words[20]), 128'h80);
        check("digits_b2w14", 128'(words[30]), 128'h280);

        // Abort after 7 words of block 1, then a clean "abc"
        send_msg(s_alnum, 1'b0, 7);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_dig_valid", 128'(bus.dig_valid), 128'd0);
        check("abort_s_ready",   128'(bus.s_ready),   128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_stale", 128'(bus.dig_valid), 128'd0);
        send_msg("abc", 1'b0, 99);
        get_digest("abort_abc", 1'b1, 128'h900150983cd24fb0d6963f7d28e17f72, 0, got);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
